// File: rtl/fact_accel.sv
// fact_accel: register-mapped iterative factorial engine, one multiply per cycle,
// with run-time overflow detection against DATA_W.
module fact_accel #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        a,
    input  logic              we,
    input  logic [N_W-1:0]    wd,
    output logic [DATA_W-1:0] rd,
    output logic              irq
);
    typedef enum logic [1:0] {IDLE, CALC, DONE, ERR} state_t;
    state_t              r_state, w_state_nxt;
    logic [N_W-1:0]      r_n, r_cnt;
    logic [DATA_W-1:0]   r_acc, r_result;
    logic                r_irq_en;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_go, w_accept, w_last, w_ovf, w_busy, w_done, w_err;

    assign w_go     = we && a == 2'd1 && wd[0];
    assign w_accept = w_go && r_state != CALC;
    assign w_last   = r_cnt <= N_W'(1);
    assign w_prod   = {{DATA_W{1'b0}}, r_acc} * {{(2*DATA_W-N_W){1'b0}}, r_cnt};
    assign w_ovf    = |w_prod[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == CALC) w_state_nxt = w_last ? DONE : w_ovf ? ERR : CALC;
        else if (w_go)       w_state_nxt = CALC;
    end

    // busy/done/err are pure decodes of the state, so GO clears them together
    always_comb begin
        w_busy = r_state == CALC;
        w_done = r_state == DONE || r_state == ERR;
        w_err  = r_state == ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n      <= '0;
            r_irq_en <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (we && a == 2'd0) r_n <= wd;
            if (we && a == 2'd1) r_irq_en <= wd[1];
            if (w_accept) begin
                r_acc <= DATA_W'(1);
                r_cnt <= r_n;
            end else if (r_state == CALC) begin
                if (w_last)     r_result <= r_acc;
                else if (w_ovf) r_result <= '0;
                else begin
                    r_acc <= w_prod[DATA_W-1:0];
                    r_cnt <= r_cnt - N_W'(1);
                end
            end
        end
    end

    always_comb
        rd = (a == 2'd0) ? DATA_W'(r_n) :
             (a == 2'd1) ? DATA_W'({r_irq_en, 1'b0}) :
             (a == 2'd2) ? DATA_W'({w_busy, w_err, w_done}) : r_result;

    assign irq = r_irq_en & w_done;
endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: directed checks of the factorial accelerator, 32-bit and 16-bit builds.
module tb_fact_accel;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  a   = 2'd0;
    logic        we  = 1'b0;
    logic [3:0]  wd  = 4'd0;
    logic [31:0] rd;
    logic        irq;
    logic [15:0] rd16;
    logic        irq16;
    int checks = 0;
    int failures = 0;

    fact_accel #(.DATA_W(32), .N_W(4)) dut (.clk(clk), .rst(rst), .a(a), .we(we), .wd(wd), .rd(rd), .irq(irq));
    fact_accel #(.DATA_W(16), .N_W(4)) dut16 (.clk(clk), .rst(rst), .a(a), .we(we), .wd(wd), .rd(rd16), .irq(irq16));

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] aa, input logic [3:0] d);
        @(negedge clk);
        a = aa; we = 1'b1; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rdr(input logic [1:0] aa, output logic [31:0] v);
        a = aa; #1; v = rd;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #12;
        for (int i = 0; i < 4; i++) begin
            rdr(2'(i), v);
            checks++;
            if (v !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got=%0h exp=0", i, v); end
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] v;
        wr(2'd0, 4'd3); wr(2'd1, 4'd1);
        for (int e = 1; e <= 2; e++) begin
            step(); rdr(2'd2, v);
            checks++;
            if (v !== 32'h4) begin failures++; $display("FAIL basic_busy_e%0d got=%0h exp=4", e, v); end
        end
        step(); rdr(2'd2, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL basic_done got=%0h exp=1", v); end
        rdr(2'd3, v);
        checks++;
        if (v !== 32'd6) begin failures++; $display("FAIL basic_result got=%0d exp=6", v); end
        repeat (10) step();
        rdr(2'd3, v);
        checks++;
        if (v !== 32'd6) begin failures++; $display("FAIL basic_hold got=%0d exp=6", v); end
    endtask

    task automatic test_exhaustive();
        logic [31:0] s, v;
        longint f;
        int e, lat;
        for (int n = 0; n <= 12; n++) begin
            f = 1;
            for (int i = 2; i <= n; i++) f = f * i;
            lat = (n < 1) ? 1 : n;
            wr(2'd0, 4'(n)); wr(2'd1, 4'd1);
            e = 0;
            do begin step(); e++; rdr(2'd2, s); end while (!s[0] && e < 20);
            rdr(2'd3, v);
            checks++;
            if (e != lat || s !== 32'h1 || v !== 32'(f)) begin
                failures++;
                $display("FAIL fact_%0d got edges=%0d status=%0h result=%0d exp edges=%0d status=1 result=%0d", n, e, s, v, lat, f);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(2'd0, 4'd13); wr(2'd1, 4'd1);
        repeat (11) step();
        rdr(2'd2, v);
        checks++;
        if (v !== 32'h4) begin failures++; $display("FAIL ovf_busy_e11 got=%0h exp=4", v); end
        step(); rdr(2'd2, v);
        checks++;
        if (v !== 32'h3) begin failures++; $display("FAIL ovf_status got=%0h exp=3", v); end
        rdr(2'd3, v);
        checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL ovf_result got=%0d exp=0", v); end
        wr(2'd0, 4'd4); wr(2'd1, 4'd1);
        rdr(2'd2, v);
        checks++;
        if (v !== 32'h4) begin failures++; $display("FAIL ovf_clear got=%0h exp=4", v); end
        repeat (4) step();
        rdr(2'd3, v);
        checks++;
        if (v !== 32'd24) begin failures++; $display("FAIL ovf_recover got=%0d exp=24", v); end
    endtask

    task automatic test_go_in_calc();
        logic [31:0] v;
        wr(2'd0, 4'd10); wr(2'd1, 4'd1);
        repeat (2) step();
        wr(2'd1, 4'd1);
        wr(2'd0, 4'd2);
        repeat (5) step();
        rdr(2'd2, v);
        checks++;
        if (v !== 32'h4) begin failures++; $display("FAIL calc_busy_e9 got=%0h exp=4", v); end
        step(); rdr(2'd2, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL calc_done_e10 got=%0h exp=1", v); end
        rdr(2'd3, v);
        checks++;
        if (v !== 32'd3628800) begin failures++; $display("FAIL calc_result got=%0d exp=3628800", v); end
        rdr(2'd0, v);
        checks++;
        if (v !== 32'd2) begin failures++; $display("FAIL calc_n_readback got=%0d exp=2", v); end
        rdr(2'd1, v);
        checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL calc_ctrl_readback got=%0h exp=0", v); end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        wr(2'd1, 4'd2);
        rdr(2'd1, v);
        checks++;
        if (v !== 32'd2) begin failures++; $display("FAIL irq_en_readback got=%0h exp=2", v); end
        wr(2'd0, 4'd5);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_pre_go got=%b exp=1", irq); end
        wr(2'd1, 4'd3);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_drop got=%b exp=0", irq); end
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (irq !== 1'b0) begin failures++; $display("FAIL irq_busy_e%0d got=%b exp=0", e, irq); end
        end
        step(); rdr(2'd3, v);
        checks++;
        if (irq !== 1'b1 || v !== 32'd120) begin failures++; $display("FAIL irq_done got irq=%b result=%0d exp irq=1 result=120", irq, v); end
        wr(2'd1, 4'd3);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_drop2 got=%b exp=0", irq); end
        repeat (6) step();
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        wr(2'd0, 4'd12); wr(2'd1, 4'd1);
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            rdr(2'(i), v);
            checks++;
            if (v !== 32'd0) begin failures++; $display("FAIL arst_reg%0d got=%0h exp=0", i, v); end
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
        @(negedge clk); rst = 1'b1;
        wr(2'd0, 4'd3); wr(2'd1, 4'd1);
        repeat (3) step();
        rdr(2'd3, v);
        checks++;
        if (v !== 32'd6) begin failures++; $display("FAIL arst_recover got=%0d exp=6", v); end
    endtask

    task automatic test_w16();
        int e;
        wr(2'd0, 4'd8); wr(2'd1, 4'd1);
        e = 0;
        do begin step(); e++; a = 2'd2; #1; end while (!rd16[0] && e < 20);
        a = 2'd3; #1;
        checks++;
        if (rd16 !== 16'd40320) begin failures++; $display("FAIL w16_fact8 got=%0d exp=40320", rd16); end
        wr(2'd0, 4'd9); wr(2'd1, 4'd1);
        e = 0;
        do begin step(); e++; a = 2'd2; #1; end while (!rd16[0] && e < 20);
        checks++;
        if (rd16 !== 16'h3) begin failures++; $display("FAIL w16_fact9_err got=%0h exp=3", rd16); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive();
        test_overflow();
        test_go_in_calc();
        test_irq();
        test_async_reset();
        test_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
